// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC, IF/ID register with valid/ready hand-off, redirect/flush, fault detection.
// Optional FETCH_HALT_ON_ZERO_EN: an all-zero instruction word stops fetch in a HALT state.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          MEM_DEPTH = 512
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] Addr,
    input  logic [31:0] Inst,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic        halted,
    output logic        fault
);

    // state   | meaning
    // S_FETCH | normal fetch: redirect > stall > advance
    // S_FAULT | stopped on illegal address; IF/ID drains, PC frozen
    // S_HALT  | stopped on zero word (FETCH_HALT_ON_ZERO_EN only)
`ifdef FETCH_HALT_ON_ZERO_EN
    typedef enum logic [1:0] {S_FETCH, S_FAULT, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_FETCH, S_FAULT} state_t;
`endif

    localparam logic [32:0] DEPTH = 33'(MEM_DEPTH);

    state_t      state;
    logic [31:0] pc;
    logic [32:0] pc_next;
    logic        br_bad;
    logic        stall;

    // one extra bit so PC+4 never wraps before the range compare
    assign pc_next = {1'b0, pc} + 33'd4;
    assign br_bad  = (br_target[1:0] != 2'b00) || ({1'b0, br_target} >= DEPTH);
    assign stall   = id_valid && !id_ready;
    assign Addr    = pc;

`ifndef FETCH_HALT_ON_ZERO_EN
    assign halted = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            id_valid <= 1'b0;
            id_inst  <= 32'h0;
            id_pc    <= 32'h0;
            fault    <= 1'b0;
`ifdef FETCH_HALT_ON_ZERO_EN
            halted   <= 1'b0;
`endif
        end else begin
            case (state)
                S_FETCH: begin
                    if (br_valid) begin
                        id_valid <= 1'b0;
                        if (br_bad) begin
                            state <= S_FAULT;
                            fault <= 1'b1;
                        end else begin
                            pc <= br_target;
                        end
                    end else if (!stall) begin
`ifdef FETCH_HALT_ON_ZERO_EN
                        if (Inst == 32'h0) begin
                            id_valid <= 1'b0;
                            state    <= S_HALT;
                            halted   <= 1'b1;
                        end else
`endif
                        begin
                            id_inst  <= Inst;
                            id_pc    <= pc;
                            id_valid <= 1'b1;
                            // last legal word: keep it, then stop with PC held
                            if (pc_next >= DEPTH) begin
                                state <= S_FAULT;
                                fault <= 1'b1;
                            end else begin
                                pc <= pc_next[31:0];
                            end
                        end
                    end
                end
                default: begin
                    if (id_ready) begin
                        id_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: expected transfers are queued by stimulus, a negedge monitor checks them.
module tb_inst_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] Addr;
    logic [31:0] Inst;
    logic        br_valid;
    logic [31:0] br_target;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        halted;
    logic        fault;

    logic [31:0] mem [0:127];
    exp_t        sb[$];
    int          checks;
    int          errors;

    inst_fetch_unit #(.RESET_PC(32'h0), .MEM_DEPTH(512)) dut (
        .clk       (clk),
        .reset     (reset),
        .Addr      (Addr),
        .Inst      (Inst),
        .br_valid  (br_valid),
        .br_target (br_target),
        .id_ready  (id_ready),
        .id_valid  (id_valid),
        .id_inst   (id_inst),
        .id_pc     (id_pc),
        .halted    (halted),
        .fault     (fault)
    );

    assign Inst = (Addr < 32'd512) ? mem[Addr[8:2]] : 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] inst);
        exp_t e;
        e.pc   = pc;
        e.inst = inst;
        sb.push_back(e);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_addr"},     Addr, 32'h0);
        chk({tag, "_id_valid"}, {31'h0, id_valid}, 32'h0);
        chk({tag, "_id_inst"},  id_inst, 32'h0);
        chk({tag, "_id_pc"},    id_pc, 32'h0);
        chk({tag, "_fault"},    {31'h0, fault}, 32'h0);
        chk({tag, "_halted"},   {31'h0, halted}, 32'h0);
    endtask

    // transfer happens on the next rising edge when valid & ready are seen here
    always @(negedge clk) begin
        if (!reset && id_valid && id_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_transfer: got pc %h inst %h expected none", id_pc, id_inst);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("xfer_pc", id_pc, e.pc);
                chk("xfer_inst", id_inst, e.inst);
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[0]   = 32'h15;
        mem[1]   = 32'h61;
        mem[2]   = 32'h23;
        mem[3]   = 32'h81;
        mem[127] = 32'h77;   // word at 0x1FC, last legal address

        reset = 1'b1; id_ready = 1'b1; br_valid = 1'b0; br_target = 32'h0;
        step(); step();
        reset = 1'b0;
        check_reset("rst0");

        // straight-line fetch
        push(32'h0, 32'h15); push(32'h4, 32'h61); push(32'h8, 32'h23); push(32'hC, 32'h81);
        step();
        chk("seq_addr4", Addr, 32'h4);
        chk("seq_valid", {31'h0, id_valid}, 32'h1);
        step(); chk("seq_addr8", Addr, 32'h8);
        step(); chk("seq_addrC", Addr, 32'hC);
        step(); chk("seq_addr10", Addr, 32'h10);
`ifdef FETCH_HALT_ON_ZERO_EN
        step();
        chk("halt_halted", {31'h0, halted}, 32'h1);
        chk("halt_valid", {31'h0, id_valid}, 32'h0);
        chk("halt_addr", Addr, 32'h10);
        step(); step();
        chk("halt_addr_frozen", Addr, 32'h10);
        chk("halt_still", {31'h0, halted}, 32'h1);
`else
        push(32'h10, 32'h0); push(32'h14, 32'h0);
        step(); step(); step();
        chk("zero_pc", id_pc, 32'h18);
        chk("zero_inst", id_inst, 32'h0);
        chk("zero_halted", {31'h0, halted}, 32'h0);
`endif
        reset = 1'b1; step(); reset = 1'b0;
        check_reset("rst1");

        // decode back-pressure
        push(32'h0, 32'h15); push(32'h4, 32'h61);
        step(); step();
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_inst", id_inst, 32'h61);
            chk("stall_pc", id_pc, 32'h4);
            chk("stall_addr", Addr, 32'h8);
        end
        id_ready = 1'b1;
        step();
        chk("unstall_inst", id_inst, 32'h23);
        chk("unstall_pc", id_pc, 32'h8);
        reset = 1'b1; step(); reset = 1'b0;
        check_reset("rst2");

        // redirect while stalled
        id_ready = 1'b0;
        step();
        chk("pre_br_inst", id_inst, 32'h15);
        br_valid = 1'b1; br_target = 32'hC;
        step();
        chk("br_flush_valid", {31'h0, id_valid}, 32'h0);
        chk("br_addr", Addr, 32'hC);
        br_valid = 1'b0; id_ready = 1'b1;
        push(32'hC, 32'h81);
        step();
        chk("br_tgt_inst", id_inst, 32'h81);
        chk("br_tgt_pc", id_pc, 32'hC);

        // misaligned redirect
        br_valid = 1'b1; br_target = 32'h6;
        step();
        chk("mis_fault", {31'h0, fault}, 32'h1);
        chk("mis_addr", Addr, 32'h10);
        chk("mis_valid", {31'h0, id_valid}, 32'h0);
        br_target = 32'h0;
        step(); step();
        chk("mis_br_ignored", Addr, 32'h10);
        chk("mis_fault_hold", {31'h0, fault}, 32'h1);
        br_valid = 1'b0;
        reset = 1'b1; step(); reset = 1'b0;
        check_reset("rst3");

        // out-of-range redirect
        push(32'h0, 32'h15);
        step();
        br_valid = 1'b1; br_target = 32'h200;
        step();
        chk("oor_fault", {31'h0, fault}, 32'h1);
        chk("oor_addr", Addr, 32'h4);
        br_target = 32'h8;
        step();
        chk("oor_br_ignored", Addr, 32'h4);
        br_valid = 1'b0;
        reset = 1'b1; step(); reset = 1'b0;
        check_reset("rst4");

        // end of memory with drain under back-pressure
        br_valid = 1'b1; br_target = 32'h1FC; id_ready = 1'b0;
        step();
        chk("eom_addr", Addr, 32'h1FC);
        chk("eom_valid0", {31'h0, id_valid}, 32'h0);
        br_valid = 1'b0;
        step();
        chk("eom_fault", {31'h0, fault}, 32'h1);
        chk("eom_inst", id_inst, 32'h77);
        chk("eom_pc", id_pc, 32'h1FC);
        step(); step();
        chk("eom_pending", {31'h0, id_valid}, 32'h1);
        chk("eom_addr_hold", Addr, 32'h1FC);
        push(32'h1FC, 32'h77);
        id_ready = 1'b1;
        step();
        chk("eom_drained", {31'h0, id_valid}, 32'h0);
        reset = 1'b1; step(); reset = 1'b0;
        check_reset("rst5");

        // restart after fault
        push(32'h0, 32'h15);
        step();
        chk("restart_inst", id_inst, 32'h15);
        chk("restart_addr", Addr, 32'h4);
        @(negedge clk);
        #1 id_ready = 1'b0;
        step();
        chk("sb_empty", sb.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
